// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - RV32 PC register and fetch sequencer (optional PC_MISALIGN_TRAP_EN)
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            halted,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            accept;
  logic            misalign_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_misaligned;

  assign pc_plus4    = pc + XLEN'(4);
  assign imem_addr   = pc;
  assign halted      = (state == ST_HALTED);

  // Requests only go out on a clean fetch cycle, so a redirect/trap never produces a wrong-path fetch
  assign imem_req = (state == ST_FETCH) && !stall && !redirect_valid && !trap_req;
  assign accept   = imem_req && imem_ack;

`ifdef PC_MISALIGN_TRAP_EN
  assign redirect_misaligned = (redirect_target[1:0] != 2'b00);
  assign redirect_pc         = redirect_misaligned ? TRAP_VECTOR : redirect_target;
`else
  assign redirect_misaligned = 1'b0;
  assign redirect_pc         = {redirect_target[XLEN-1:2], 2'b00};
`endif

  // Next state and next PC: trap beats redirect beats sequential accept; stall only blocks accept
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    misalign_next = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (trap_req) begin
          pc_next = TRAP_VECTOR;
        end else begin
          if (redirect_valid) begin
            pc_next       = redirect_pc;
            misalign_next = redirect_misaligned;
          end else if (accept) begin
            pc_next = pc_plus4;
          end
          if (halt_req) state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (trap_req) begin
          pc_next    = TRAP_VECTOR;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_BOOT;
        pc_next    = RESET_VECTOR;
      end
    endcase
  end

  // State, PC and registered fetch outputs; reset discards any in-flight ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_BOOT;
      pc           <= RESET_VECTOR;
      fetch_valid  <= 1'b0;
      fetch_pc     <= RESET_VECTOR;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      fetch_valid  <= accept;
      misalign_err <= misalign_next;
      if (accept) fetch_pc <= pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        halted;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    trap_req = 1'b0; halt_req = 1'b0; imem_ack = 1'b1;
    step(); step();

    // Reset values
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // 1: boot bubble then sequential fetch 0,4,8
    rst = 1'b0;
    #1;
    check("boot_bubble_req", {31'd0, imem_req}, 32'd0);
    step();
    check("fetch0_req", {31'd0, imem_req}, 32'd1);
    check("fetch0_addr", imem_addr, 32'h0);
    check("fetch0_no_valid", {31'd0, fetch_valid}, 32'd0);
    step();
    check("fv0", {31'd0, fetch_valid}, 32'd1);
    check("fpc0", fetch_pc, 32'h0);
    check("addr4", imem_addr, 32'h4);
    step();
    check("fpc4", fetch_pc, 32'h4);
    step();
    check("fv8", {31'd0, fetch_valid}, 32'd1);
    check("fpc8", fetch_pc, 32'h8);

    // 2: wrap at 0xFFFF_FFFC
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    #1;
    check("redir_no_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    check("redir_no_fv", {31'd0, fetch_valid}, 32'd0);
    check("addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check("fpc_top", fetch_pc, 32'hFFFF_FFFC);
    check("addr_wrap", imem_addr, 32'h0);

    // 3: stall holds PC at 0x1000
    redirect_valid = 1'b1; redirect_target = 32'h1000;
    step();
    redirect_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_addr", imem_addr, 32'h1000);
      step();
      check("stall_no_fv", {31'd0, fetch_valid}, 32'd0);
    end
    stall = 1'b0;
    #1;
    check("unstall_req", {31'd0, imem_req}, 32'd1);
    step();
    check("unstall_fv", {31'd0, fetch_valid}, 32'd1);
    check("unstall_fpc", fetch_pc, 32'h1000);
    check("unstall_addr", imem_addr, 32'h1004);

    // 4: redirect overrides stall; trap overrides redirect
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h2000;
    step();
    check("rs_no_fv", {31'd0, fetch_valid}, 32'd0);
    check("rs_addr", imem_addr, 32'h2000);
    trap_req = 1'b1; redirect_target = 32'h3000;
    step();
    check("trap_no_fv", {31'd0, fetch_valid}, 32'd0);
    check("trap_addr", imem_addr, 32'h100);
    trap_req = 1'b0; stall = 1'b0;

    // 5: halt with same-cycle accept at 0x40
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_fv", {31'd0, fetch_valid}, 32'd1);
    check("halt_fpc", fetch_pc, 32'h40);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_req0", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halted_hold", {31'd0, halted}, 32'd1);
      check("halted_noreq", {31'd0, imem_req}, 32'd0);
      check("halted_addr", imem_addr, 32'h44);
      check("halted_no_fv", {31'd0, fetch_valid}, 32'd0);
    end
    redirect_valid = 1'b0; trap_req = 1'b1;
    step();
    trap_req = 1'b0;
    check("wake_halted", {31'd0, halted}, 32'd0);
    check("wake_addr", imem_addr, 32'h100);
    halt_req = 1'b1; trap_req = 1'b1;
    step();
    halt_req = 1'b0; trap_req = 1'b0;
    check("halt_trap_stays", {31'd0, halted}, 32'd0);
    check("halt_trap_addr", imem_addr, 32'h100);

    // 6: misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h2002;
    step();
    redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_addr", imem_addr, 32'h100);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
`else
    check("mis_addr", imem_addr, 32'h2000);
    check("mis_err", {31'd0, misalign_err}, 32'd0);
`endif
    step();
    check("mis_err_clear", {31'd0, misalign_err}, 32'd0);

    // Asynchronous reset mid-operation
    step();
    rst = 1'b1;
    #1;
    check("arst_addr", imem_addr, 32'h0);
    check("arst_fv", {31'd0, fetch_valid}, 32'd0);
    check("arst_fpc", fetch_pc, 32'h0);
    check("arst_req", {31'd0, imem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
